// File: rtl/mux_sel_sequencer.sv
// Upstream stage of the 4:1 bit mux: accepts a 4-bit word over valid/ready and
// walks sel across all four positions, holding each for DWELL cycles.
//
// state | meaning
// IDLE  | no word in flight; in_ready=1, waiting for a transfer
// SCAN  | stepping sel through the captured word; in_ready only on the final cycle
module mux_sel_sequencer #(
    parameter int DWELL = 1,
    parameter int CNT_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    input  logic       in_dir,
    output logic [3:0] abcd,
    output logic [1:0] sel,
    output logic       sel_valid,
    output logic       sel_last,
    output logic       busy,
    output logic       done
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] DWELL_M1 = CNT_W'(DWELL - 1);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [3:0]       r_abcd, w_abcd_nxt;
    logic [1:0]       r_sel, w_sel_nxt;
    logic             r_dir, w_dir_nxt;
    logic             r_sel_valid, w_sel_valid_nxt;
    logic             r_sel_last, w_sel_last_nxt;
    logic             r_done, w_done_nxt;

    logic             w_final;
    logic             w_in_ready;
    logic             w_xfer;
    logic [1:0]       w_sel_step;
    logic [1:0]       w_last_pos;

    // Final cycle of a word: last position and last dwell cycle of it.
    assign w_final    = (r_state == SCAN) && r_sel_last && (r_cnt == DWELL_M1);
    assign w_in_ready = !rst && ((r_state == IDLE) || w_final);
    assign w_xfer     = in_valid && w_in_ready;
    assign w_sel_step = r_dir ? (r_sel - 2'd1) : (r_sel + 2'd1);
    assign w_last_pos = r_dir ? 2'd0 : 2'd3;

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_abcd_nxt      = r_abcd;
        w_sel_nxt       = r_sel;
        w_dir_nxt       = r_dir;
        w_sel_valid_nxt = r_sel_valid;
        w_sel_last_nxt  = r_sel_last;
        w_done_nxt      = 1'b0;

        case (r_state)
            SCAN: begin
                if (r_cnt == DWELL_M1) begin
                    w_cnt_nxt = '0;
                    if (r_sel_last) begin
                        w_done_nxt      = 1'b1;
                        w_state_nxt     = IDLE;
                        w_sel_valid_nxt = 1'b0;
                        w_sel_last_nxt  = 1'b0;
                    end else begin
                        w_sel_nxt      = w_sel_step;
                        w_sel_last_nxt = (w_sel_step == w_last_pos);
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: ;
        endcase

        // A transfer only happens in IDLE or on the final cycle, so loading the
        // new word here overrides the end-of-scan values for back-to-back words.
        if (w_xfer) begin
            w_state_nxt     = SCAN;
            w_cnt_nxt       = '0;
            w_abcd_nxt      = in_data;
            w_dir_nxt       = in_dir;
            w_sel_nxt       = in_dir ? 2'd3 : 2'd0;
            w_sel_valid_nxt = 1'b1;
            w_sel_last_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_abcd      <= '0;
            r_sel       <= '0;
            r_dir       <= 1'b0;
            r_sel_valid <= 1'b0;
            r_sel_last  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_abcd      <= w_abcd_nxt;
            r_sel       <= w_sel_nxt;
            r_dir       <= w_dir_nxt;
            r_sel_valid <= w_sel_valid_nxt;
            r_sel_last  <= w_sel_last_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign in_ready  = w_in_ready;
    assign abcd      = r_abcd;
    assign sel       = r_sel;
    assign sel_valid = r_sel_valid;
    assign sel_last  = r_sel_last;
    assign busy      = r_sel_valid;
    assign done      = r_done;

endmodule

// File: doc/mux_sel_sequencer.md
Name: mux_sel_sequencer

Overview:
- Upstream stage of the 4:1 bit mux: accepts a 4-bit word over a valid/ready handshake and holds it on abcd.
- Steps sel through all four positions in ascending or descending order, holding each position for DWELL cycles, so the downstream mux emits the word bit-serially.
- Flags each valid select, marks the last one, and pulses done at scan end.
- Supports back-to-back words with no idle cycle.

Parameters:
- DWELL, 1, cycles each sel value is held; legal range 1..2**CNT_W-1.
- CNT_W, 4, width of the dwell counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  in_data/in_dir are valid.
- in_ready  out  1  sequencer can accept a word this cycle.
- in_data  in  4  word to serialize.
- in_dir  in  1  0 = sel order 0,1,2,3; 1 = sel order 3,2,1,0.
- abcd  out  4  captured word, drives the mux data input.
- sel  out  2  mux select.
- sel_valid  out  1  sel/abcd are meaningful this cycle.
- sel_last  out  1  final sel position of the current word (asserted for all of its DWELL cycles).
- busy  out  1  scan in progress (equals sel_valid).
- done  out  1  one-cycle pulse in the cycle after the last dwell cycle of a word.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, on rst.
- Reset values (sampled at the rst edge):
  - state IDLE; abcd=0; sel=0; sel_valid=0; sel_last=0; busy=0; done=0; dwell counter=0.
  - in_ready is forced 0 while rst=1.
- Reset mid-scan: abandons the word, no done pulse, all outputs take their reset values on the next edge.
- State machine: IDLE and SCAN. All outputs except in_ready are registered.
- IDLE:
  - in_ready=1.
  - A transfer occurs when in_valid and in_ready are both high at a rising edge.
  - On a transfer, the next cycle has: abcd=in_data, stored dir=in_dir, sel=0 (or 3 if dir=1), sel_valid=1, dwell counter=0. State goes to SCAN.
  - Latency from the transfer edge to the first sel_valid is 1 cycle.
- SCAN:
  - The dwell counter increments each cycle.
  - When the counter reaches DWELL-1 it clears, and sel advances by +1 (dir=0) or -1 (dir=1).
  - sel_last=1 while sel==3 (dir=0) or sel==0 (dir=1).
  - Each word occupies exactly 4*DWELL sel_valid cycles.
  - abcd and dir are held constant for the whole scan.
  - in_valid is ignored in SCAN except in the final cycle (next bullet).
- Final cycle (sel_last=1 and counter==DWELL-1):
  - in_ready=1 (combinational from state and counter).
  - With a transfer: the next cycle starts the new word immediately (new abcd, first sel, sel_valid stays 1, no gap) and done=1 in that same cycle.
  - Without a transfer: the next cycle has sel_valid=0, done=1, state IDLE, and sel and abcd hold their last values.
- in_ready=0 in every other SCAN cycle. Upstream must hold in_valid/in_data stable until the transfer.
- DWELL=1: every cycle is a final-dwell cycle for its sel. sel changes every cycle, and the back-to-back rule still applies, giving 4-cycle word throughput.
- Wrap-around: sel never wraps within a word. The scan ends at the last position, and the next word restarts from its own first position.
- Downstream output: the mux bit driven by this block is valid while sel_valid=1.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with in_valid=1 -> in_ready=0, all outputs 0. After rst=0: in_ready=1, no transfer until in_valid is seen.
- Single word ascending, DWELL=1: in_data=4'b1010, in_dir=0 -> sel 0,1,2,3 on cycles T+1..T+4, mux output 0,1,0,1, sel_last only at T+4, done at T+5, in_ready=1 at T+5.
- Descending, DWELL=3: in_data=4'b0011, in_dir=1 -> sel=3 for 3 cycles, then 2, 1, 0 for 3 cycles each. Mux output sequence 0,0,0,0,0,0,1,1,1,1,1,1. 12 sel_valid cycles, done on the 13th.
- Back-to-back, DWELL=2: words 4'hF (dir=0) then 4'h0 (dir=1) presented continuously -> second transfer on the final cycle of the first word. Expect 16 contiguous sel_valid cycles, sel 0,0,1,1,2,2,3,3,3,3,2,2,1,1,0,0, and done pulses both at the first word boundary and after the second word.
- Backpressure: in_valid held high with changing in_data during SCAN (not the final cycle) -> in_ready=0, abcd unchanged, next word accepted only on the final cycle.
- Reset mid-scan: rst=1 while sel=2 -> next cycle sel_valid=0, abcd=0, sel=0, no done pulse. A new word after rst=0 scans normally from its first position.
